// File: rtl/mealy_pkg.sv
// Shared definitions for the table-driven Mealy automaton: entry layout and address packing.
package mealy_pkg;

  // Entry layout, MSB to LSB: {upd, out[out_w-1:0], next[sw-1:0]}.
  localparam int unsigned UpdW = 1;

  // Total entry width for a given state width and output width.
  function automatic int unsigned entry_width(input int unsigned sw, input int unsigned out_w);
    return UpdW + out_w + sw;
  endfunction

  // Bit position of the out field's LSB inside an entry.
  function automatic int unsigned out_lsb(input int unsigned sw);
    return sw;
  endfunction

  // Bit position of the upd flag inside an entry.
  function automatic int unsigned upd_bit(input int unsigned sw, input int unsigned out_w);
    return sw + out_w;
  endfunction

  // Table address {state, sym}; the caller truncates to its address width.
  function automatic logic [31:0] pack_addr(input logic [31:0] st, input logic [31:0] sym,
                                            input int unsigned in_w);
    return (st << in_w) | sym;
  endfunction

endpackage

// File: rtl/mealy_trans_table.sv
// Transition table: entry storage with per-entry valid bits, one write port with range check,
// one asynchronous read port.
module mealy_trans_table
  import mealy_pkg::*;
#(
  parameter int unsigned N_STATES = 4,
  parameter int unsigned IN_W     = 2,
  parameter int unsigned OUT_W    = 2,
  localparam int unsigned SW      = $clog2(N_STATES),
  localparam int unsigned AW      = SW + IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SW-1:0]    wnext,
  input  logic [OUT_W-1:0] wout,
  input  logic             wupd,
  output logic             err,
  input  logic [AW-1:0]    raddr,
  output logic [SW-1:0]    rnext,
  output logic [OUT_W-1:0] rout,
  output logic             rupd,
  output logic             rvalid
);

  localparam int unsigned Depth  = 2 ** AW;
  localparam int unsigned EntryW = entry_width(SW, OUT_W);
  localparam int unsigned OutLsb = out_lsb(SW);
  localparam int unsigned UpdBit = upd_bit(SW, OUT_W);

  logic [EntryW-1:0] mem [Depth];
  logic [Depth-1:0]  valid_q;
  logic              bad_range;
  logic              wr_ok;
  logic              err_q;
  logic [EntryW-1:0] rd_entry;

  // Reject writes that name a nonexistent state, either as source or as destination.
  always_comb begin
    bad_range = (32'(wnext) >= N_STATES) || (32'(waddr[AW-1:IN_W]) >= N_STATES);
    wr_ok     = we && !bad_range;
  end

  // Payload storage: never reset, only valid bits decide whether an entry is usable.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[waddr] <= {wupd, wout, wnext};
    end
  end

  // Valid bits and the reject pulse; reset empties the table logically.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= we && bad_range;
      if (wr_ok) begin
        valid_q[waddr] <= 1'b1;
      end
    end
  end

  // Asynchronous read returns pre-edge contents, so a same-cycle write is seen by the next step.
  always_comb begin
    rd_entry = mem[raddr];
    rnext    = rd_entry[SW-1:0];
    rout     = rd_entry[OutLsb +: OUT_W];
    rupd     = rd_entry[UpdBit];
    rvalid   = valid_q[raddr];
    err      = err_q;
  end

endmodule

// File: rtl/mealy_table_fsm.sv
// Run-time programmable Mealy automaton: state/output registers stepped through a loadable
// transition table, with recovery from illegal state encodings.
module mealy_table_fsm
  import mealy_pkg::*;
#(
  parameter int unsigned N_STATES    = 4,
  parameter int unsigned IN_W        = 2,
  parameter int unsigned OUT_W       = 2,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned RESET_OUT   = 0,
  parameter int unsigned DEFAULT_OUT = 0,
  localparam int unsigned SW         = $clog2(N_STATES),
  localparam int unsigned AW         = SW + IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sym,
  output logic [OUT_W-1:0] out_sym,
  output logic             out_upd,
  output logic [SW-1:0]    state,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SW-1:0]    cfg_next,
  input  logic [OUT_W-1:0] cfg_out,
  input  logic             cfg_upd,
  output logic             cfg_err,
  output logic             fault
);

  logic [SW-1:0]    state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             upd_q, upd_d;
  logic             fault_q, fault_d;
  logic [AW-1:0]    rd_addr;
  logic [SW-1:0]    e_next;
  logic [OUT_W-1:0] e_out;
  logic             e_upd;
  logic             e_valid;
  logic             illegal;

  assign rd_addr = AW'(pack_addr(32'(state_q), 32'(in_sym), IN_W));

  mealy_trans_table #(
    .N_STATES(N_STATES),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wnext (cfg_next),
    .wout  (cfg_out),
    .wupd  (cfg_upd),
    .err   (cfg_err),
    .raddr (rd_addr),
    .rnext (e_next),
    .rout  (e_out),
    .rupd  (e_upd),
    .rvalid(e_valid)
  );

  // Next-state/output: recovery wins over stepping; unprogrammed entries hold everything.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    upd_d   = 1'b0;
    fault_d = 1'b0;
    illegal = (32'(state_q) >= N_STATES);
    if (illegal) begin
      state_d = SW'(RESET_STATE);
      out_d   = OUT_W'(DEFAULT_OUT);
      fault_d = 1'b1;
    end else if (in_valid && e_valid) begin
      state_d = e_next;
      if (e_upd) begin
        out_d = e_out;
        upd_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SW'(RESET_STATE);
      out_q   <= OUT_W'(RESET_OUT);
      upd_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
      fault_q <= fault_d;
    end
  end

  assign state   = state_q;
  assign out_sym = out_q;
  assign out_upd = upd_q;
  assign fault   = fault_q;

endmodule
